// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
// Shared types and helpers for the uart_tx write-port arbiter.
//   state_t   : arbiter FSM states
//   rr_pick_t : result of a round-robin search (found flag + winning index)
//   rr_pick() : round-robin search over a valid vector, starting at ptr and
//               wrapping at n (n need not be a power of two)
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    localparam int MAX_N  = 16;
    localparam int MAX_PW = 4;

    typedef struct packed {
        logic              found;
        logic [MAX_PW-1:0] idx;
    } rr_pick_t;

    // Lowest-priority position is the one just before ptr, so the previous
    // winner (ptr-1) is served last.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_N-1:0]  valid,
        input logic [MAX_PW-1:0] ptr,
        input int                n
    );
        rr_pick_t res;
        int       j;
        res = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                j = int'(ptr) + i;
                if (j >= n) begin
                    j = j - n;
                end
                if (!res.found && valid[j]) begin
                    res.found = 1'b1;
                    res.idx   = MAX_PW'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick over N requesters.
//   i_valid [N]          request vector
//   i_ptr   [clog2(N)]   highest-priority position this cycle
//   o_grant [N]          one-hot winner, 0 when nothing is valid
//   o_idx   [clog2(N)]   index of the winner (don't-care when !o_found)
//   o_found              at least one request was valid
module rr_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_valid,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);

    localparam int PW = $clog2(N);

    logic [MAX_N-1:0]  w_valid_ext;
    logic [MAX_PW-1:0] w_ptr_ext;
    rr_pick_t          w_pick;

    always_comb begin
        w_valid_ext         = '0;
        w_valid_ext[N-1:0]  = i_valid;
        w_ptr_ext           = '0;
        w_ptr_ext[PW-1:0]   = i_ptr;
        w_pick              = rr_pick(w_valid_ext, w_ptr_ext, N);
    end

    assign o_found = w_pick.found;
    assign o_idx   = w_pick.idx[PW-1:0];

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < N; i++) begin
            o_grant[i] = w_pick.found && (w_pick.idx == MAX_PW'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shares one uart_tx Avalon-MM write port between N byte-stream requesters.
// Round-robin arbitration with packet lock: once a requester wins, it keeps
// the port until it sends a byte flagged last, or until it idles for
// LOCK_TMO cycles in LOCK (forced release, o_lock_abort pulses).
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   i_req_valid [N]      requester i has a byte
//   i_req_data  [8N]     byte of requester i at [8i+7:8i]
//   i_req_last  [N]      byte closes requester i's packet
//   o_req_ready [N]      byte i accepted when valid & ready
//   o_avm_*              Avalon write master towards uart_tx
//   i_avm_waitrequest    uart_tx busy; write completes when low
//   o_grant     [N]      one-hot owner in WRITE/LOCK, 0 in IDLE
//   o_lock_abort         one-cycle pulse on timeout release
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no owner; round-robin pick from rr_ptr, accept byte of winner
// WRITE  | avm_write held with stable data until waitrequest is low
// LOCK   | packet open; only the owner may send, idle cycles counted
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int AAW      = 1,
    parameter int ADW      = 32,
    parameter int TX_ADDR  = 0,
    parameter int LOCK_TMO = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req_valid,
    input  logic [8*N-1:0]   i_req_data,
    input  logic [N-1:0]     i_req_last,
    output logic [N-1:0]     o_req_ready,
    output logic             o_avm_write,
    output logic [AAW-1:0]   o_avm_address,
    output logic [ADW/8-1:0] o_avm_byteenable,
    output logic [ADW-1:0]   o_avm_writedata,
    input  logic             i_avm_waitrequest,
    output logic [N-1:0]     o_grant,
    output logic             o_lock_abort
);

    localparam int PW = $clog2(N);
    localparam int TW = (LOCK_TMO > 0) ? $clog2(LOCK_TMO + 1) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_cur;
    logic [7:0]      r_hold;
    logic            r_last_q;
    logic [TW-1:0]   r_tmo;

    logic [N-1:0]    w_pick_grant;
    logic [PW-1:0]   w_pick_idx;
    logic            w_pick_found;
    logic [PW-1:0]   w_ptr_nxt;
    logic [N-1:0]    w_cur_onehot;
    logic [PW-1:0]   w_acc_idx;
    logic [7:0]      w_acc_byte;
    logic            w_acc_last;
    logic            w_accept;
    logic            w_timeout;

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .i_valid (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // Explicit wrap so non-power-of-two N never lands on an unused index.
    assign w_ptr_nxt = (w_pick_idx == PW'(N - 1)) ? '0 : w_pick_idx + PW'(1);

    always_comb begin
        w_cur_onehot = '0;
        for (int i = 0; i < N; i++) begin
            w_cur_onehot[i] = (r_cur == PW'(i));
        end
    end

    assign w_acc_idx  = (r_state == ST_LOCK) ? r_cur : w_pick_idx;
    assign w_acc_byte = i_req_data[{w_acc_idx, 3'b000} +: 8];
    assign w_acc_last = i_req_last[w_acc_idx];

    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE:  w_accept = w_pick_found;
            ST_LOCK:  w_accept = i_req_valid[r_cur];
            default:  w_accept = 1'b0;
        endcase
    end

    // Accept has priority: a byte arriving on the terminal cycle keeps the lock.
    assign w_timeout = (LOCK_TMO != 0) && (r_state == ST_LOCK) && !w_accept &&
                       (r_tmo == TW'(LOCK_TMO - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!i_avm_waitrequest) begin
                    w_state_nxt = r_last_q ? ST_IDLE : ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (w_accept) begin
                    w_state_nxt = ST_WRITE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = '0;
        o_avm_write  = 1'b0;
        o_grant      = '0;
        o_lock_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = w_pick_grant;
            end
            ST_WRITE: begin
                o_avm_write = 1'b1;
                o_grant     = w_cur_onehot;
            end
            ST_LOCK: begin
                o_req_ready  = w_cur_onehot;
                o_grant      = w_cur_onehot;
                o_lock_abort = w_timeout;
            end
            default: ;
        endcase
    end

    assign o_avm_address    = AAW'(TX_ADDR);
    assign o_avm_byteenable = (ADW/8)'(1);
    assign o_avm_writedata  = ADW'(r_hold);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
            r_cur    <= '0;
            r_hold   <= '0;
            r_last_q <= 1'b0;
            r_tmo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_hold   <= w_acc_byte;
                        r_last_q <= w_acc_last;
                        r_cur    <= w_pick_idx;
                        r_rr_ptr <= w_ptr_nxt;
                    end
                end
                ST_WRITE: begin
                    if (!i_avm_waitrequest) begin
                        r_tmo <= '0;
                    end
                end
                ST_LOCK: begin
                    if (w_accept) begin
                        r_hold   <= w_acc_byte;
                        r_last_q <= w_acc_last;
                        r_tmo    <= '0;
                    end else if (r_tmo != '1) begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
// Scoreboard bench: each test queues bytes per requester and pushes the
// writes it expects, in order; a monitor pops and compares each completed
// Avalon write. Requester bytes are presented by a driver process.
`timescale 1ns/1ps
module tb_uart_tx_arb;

    localparam int N        = 4;
    localparam int AAW      = 1;
    localparam int ADW      = 32;
    localparam int LOCK_TMO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     o_req_ready;
    logic             o_avm_write;
    logic [AAW-1:0]   o_avm_address;
    logic [ADW/8-1:0] o_avm_byteenable;
    logic [ADW-1:0]   o_avm_writedata;
    logic             avm_waitrequest;
    logic [N-1:0]     o_grant;
    logic             o_lock_abort;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .N        (N),
        .AAW      (AAW),
        .ADW      (ADW),
        .TX_ADDR  (0),
        .LOCK_TMO (LOCK_TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_req_valid       (req_valid),
        .i_req_data        (req_data),
        .i_req_last        (req_last),
        .o_req_ready       (o_req_ready),
        .o_avm_write       (o_avm_write),
        .o_avm_address     (o_avm_address),
        .o_avm_byteenable  (o_avm_byteenable),
        .o_avm_writedata   (o_avm_writedata),
        .i_avm_waitrequest (avm_waitrequest),
        .o_grant           (o_grant),
        .o_lock_abort      (o_lock_abort)
    );

    typedef struct {
        int         r;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] tx_q[N][$];
    bit         pend_acc[N];

    int n_checks    = 0;
    int n_errors    = 0;
    int wr_cycles   = 0;
    int wait_cycles = 0;
    int abort_cnt   = 0;
    int lock_cyc    = 0;
    bit prev_wait   = 0;
    logic [ADW-1:0] prev_wdata;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Driver: a byte stays presented until a cycle where valid & ready;
    // ready is sampled mid-cycle, where it equals its value at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int r = 0; r < N; r++) begin
                if (pend_acc[r]) begin
                    pend_acc[r] = 0;
                    req_valid[r] = 1'b0;
                    if (tx_q[r].size() > 0) void'(tx_q[r].pop_front());
                end
            end
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] && tx_q[r].size() > 0) begin
                    req_data[8*r +: 8] = tx_q[r][0][7:0];
                    req_last[r]        = tx_q[r][0][8];
                    req_valid[r]       = 1'b1;
                end
            end
            #1;
            for (int r = 0; r < N; r++) begin
                if (req_valid[r] && o_req_ready[r]) pend_acc[r] = 1;
            end
        end
    end

    // Monitor: sampled after all stimulus of the cycle has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                if (o_avm_write) begin
                    wr_cycles++;
                    chk_val("ready_in_write", 64'(o_req_ready), 64'(0));
                    if (avm_waitrequest) begin
                        wait_cycles++;
                        if (prev_wait) chk_val("wdata_stable", 64'(o_avm_writedata), 64'(prev_wdata));
                        prev_wait  = 1;
                        prev_wdata = o_avm_writedata;
                    end else begin
                        prev_wait = 0;
                        if (exp_q.size() == 0) begin
                            chk_val("unexpected_write", 64'(o_avm_write), 64'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk_val("wdata", 64'(o_avm_writedata), 64'({24'h0, e.d}));
                            chk_val("wr_grant", 64'(o_grant), 64'(1 << e.r));
                        end
                    end
                end else begin
                    prev_wait = 0;
                end
                if (o_grant != '0 && !o_avm_write) lock_cyc++;
                else lock_cyc = 0;
                if (o_lock_abort) begin
                    abort_cnt++;
                    chk_val("abort_cycle", 64'(lock_cyc), 64'(LOCK_TMO));
                end
            end else begin
                prev_wait = 0;
                lock_cyc  = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_tx(input int r, input logic [7:0] d, input bit last);
        tx_q[r].push_back({last, d});
    endtask

    task automatic push_exp(input int r, input logic [7:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    function automatic int busy();
        int b;
        b = exp_q.size() + int'(o_avm_write) + int'(o_grant != '0);
        for (int r = 0; r < N; r++) b += tx_q[r].size();
        return b;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            step();
            if (busy() == 0) break;
            n++;
        end
        if (n >= budget) chk_val(tag, 64'(busy()), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int r = 0; r < N; r++) begin
            tx_q[r].delete();
            pend_acc[r] = 0;
        end
        req_valid = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst         = 1'b1;
        wr_cycles   = 0;
        wait_cycles = 0;
        abort_cnt   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst             = 1'b0;
        req_valid       = '0;
        req_data        = '0;
        req_last        = '0;
        avm_waitrequest = 1'b0;
        do_reset();
        step();

        // reset state
        chk_val("rst_write",  64'(o_avm_write),      64'(0));
        chk_val("rst_wdata",  64'(o_avm_writedata),  64'(0));
        chk_val("rst_ready",  64'(o_req_ready),      64'(0));
        chk_val("rst_grant",  64'(o_grant),          64'(0));
        chk_val("rst_abort",  64'(o_lock_abort),     64'(0));
        chk_val("rst_addr",   64'(o_avm_address),    64'(0));
        chk_val("rst_be",     64'(o_avm_byteenable), 64'(1));

        // single byte, last=1, no wait
        push_exp(1, 8'h55);
        push_tx(1, 8'h55, 1);
        wait_idle("t1_drain", 20);
        chk_val("t1_wr_cycles", 64'(wr_cycles), 64'(1));
        chk_val("t1_grant_idle", 64'(o_grant), 64'(0));

        // all four valid, two rounds of single-byte packets
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < N; r++) begin
                push_exp(r, 8'(8'h10 + 4 * k + r));
                push_tx(r, 8'(8'h10 + 4 * k + r), 1);
            end
        end
        wait_idle("t2_drain", 100);
        chk_val("t2_wr_cycles", 64'(wr_cycles), 64'(8));

        // packet lock: req2 packet completes before req0 is served
        do_reset();
        push_exp(1, 8'h33);
        push_tx(1, 8'h33, 1);
        wait_idle("t3a_drain", 20);
        push_exp(2, 8'hA1);
        push_exp(2, 8'hA2);
        push_exp(2, 8'hA3);
        push_exp(0, 8'h0B);
        push_tx(2, 8'hA1, 0);
        push_tx(2, 8'hA2, 0);
        push_tx(2, 8'hA3, 1);
        push_tx(0, 8'h0B, 1);
        wait_idle("t3_drain", 100);
        chk_val("t3_abort_cnt", 64'(abort_cnt), 64'(0));

        // lock timeout: req2 stalls after 0xA1, req0 served after release
        do_reset();
        push_exp(2, 8'hA1);
        push_tx(2, 8'hA1, 0);
        n = 0;
        while (o_grant != 4'b0100 && n < 20) begin
            step();
            n++;
        end
        chk_val("t4_grant2", 64'(o_grant), 64'(4'b0100));
        push_exp(0, 8'h0C);
        push_tx(0, 8'h0C, 1);
        wait_idle("t4_drain", 200);
        chk_val("t4_abort_cnt", 64'(abort_cnt), 64'(1));

        // waitrequest held 10 cycles; req1 written first, req3 waits
        do_reset();
        avm_waitrequest = 1'b1;
        push_exp(1, 8'h99);
        push_exp(3, 8'h77);
        push_tx(1, 8'h99, 1);
        push_tx(3, 8'h77, 1);
        n = 0;
        while (wait_cycles < 10 && n < 50) begin
            step();
            n++;
        end
        avm_waitrequest = 1'b0;
        wait_idle("t5_drain", 50);
        chk_val("t5_wait_cycles", 64'(wait_cycles), 64'(10));

        // reset during WRITE: outputs drop at once, arbitration restarts at 0
        do_reset();
        avm_waitrequest = 1'b1;
        push_tx(2, 8'h5A, 1);
        n = 0;
        while (!o_avm_write && n < 20) begin
            step();
            n++;
        end
        chk_val("t6_in_write", 64'(o_avm_write), 64'(1));
        rst = 1'b0;
        #1;
        chk_val("t6_rst_write", 64'(o_avm_write), 64'(0));
        chk_val("t6_rst_grant", 64'(o_grant), 64'(0));
        do_reset();
        avm_waitrequest = 1'b0;
        push_exp(1, 8'h61);
        push_exp(3, 8'h63);
        push_tx(3, 8'h63, 1);
        push_tx(1, 8'h61, 1);
        wait_idle("t6_drain", 50);

        // byte arrives on the terminal LOCK cycle: accept beats timeout
        do_reset();
        push_exp(2, 8'hB1);
        push_exp(2, 8'hB2);
        push_tx(2, 8'hB1, 0);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            #4;
            if (lock_cyc == LOCK_TMO - 1) break;
            n++;
        end
        chk_val("t7_lock_cyc", 64'(lock_cyc), 64'(LOCK_TMO - 1));
        push_tx(2, 8'hB2, 1);
        wait_idle("t7_drain", 50);
        chk_val("t7_abort_cnt", 64'(abort_cnt), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
